// File: rtl/param_cacheline_adapter_pkg.sv
// ---------------------------------------------------------------------------
// cache_types
// Shared types for the parametrised cacheline adapter.
//   cacheline_state_t : adapter controller states
// ---------------------------------------------------------------------------
package cache_types;

  typedef enum logic [2:0] {
    LINE_IDLE        = 3'd0,
    WAIT             = 3'd1,
    SERIALIZE        = 3'd2,
    DESERIALIZE      = 3'd3,
    DESERIALIZE_DONE = 3'd4
  } cacheline_state_t;

endpackage : cache_types

// File: rtl/param_cacheline_adapter_line_beat_buffer.sv
// ---------------------------------------------------------------------------
// line_beat_buffer
// One cacheline of storage viewed as BEATS burst-wide slots.
//   clk_i, rst_ni   : clock, synchronous active-low reset (clears the line)
//   load_i          : load the whole line from load_line_i (write path)
//   beat_we_i       : write beat_wdata_i into slot beat_widx_i (read path)
//   beat_ridx_i     : slot presented on beat_rdata_o (combinational read)
//   line_o          : full stored line
// Load has priority over a beat write; the controller never asserts both.
// ---------------------------------------------------------------------------
module line_beat_buffer #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  localparam int BEATS      = LINE_WIDTH / BURST_WIDTH,
  localparam int IDX_W      = $clog2(BEATS)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   load_i,
  input  logic [LINE_WIDTH-1:0]  load_line_i,
  input  logic                   beat_we_i,
  input  logic [IDX_W-1:0]       beat_widx_i,
  input  logic [BURST_WIDTH-1:0] beat_wdata_i,
  input  logic [IDX_W-1:0]       beat_ridx_i,
  output logic [BURST_WIDTH-1:0] beat_rdata_o,
  output logic [LINE_WIDTH-1:0]  line_o
);

  logic [BEATS-1:0][BURST_WIDTH-1:0] line_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= load_line_i;
    end else if (beat_we_i) begin
      line_q[beat_widx_i] <= beat_wdata_i;
    end
  end

  assign beat_rdata_o = line_q[beat_ridx_i];
  assign line_o       = line_q;

endmodule : line_beat_buffer

// File: rtl/param_cacheline_adapter.sv
// ---------------------------------------------------------------------------
// param_cacheline_adapter
// Bridges a line-wide cache memory port to a burst memory. Writes are sent
// as BEATS consecutive bursts (beat 0 first); reads collect BEATS in-order
// beats into one line. All outputs come straight from flops.
//
// Optional feature macro: CACHELINE_EARLY_RESTART_EN
//   When defined, the beat holding the requested address is forwarded on
//   crit_rdata_o with a one-cycle crit_valid_o pulse the cycle after it
//   arrives. When undefined, both crit outputs are tied to 0.
//
// Ports
//   clk_i, rst_ni     : clock, synchronous active-low reset
//   dfp_addr_i        : cache request byte address
//   dfp_read_i/_write_i : line requests, held until dfp_resp_o
//   dfp_wdata_i       : line to write
//   dfp_rdata_o       : assembled line, valid while dfp_resp_o
//   dfp_resp_o        : one-cycle completion pulse
//   crit_valid_o/crit_rdata_o : early-restart critical beat
//   bmem_addr_o       : line-aligned address
//   bmem_read_o       : one-cycle read command
//   bmem_write_o/bmem_wdata_o : write beat strobe and data
//   bmem_ready_i      : memory can accept a command (checked at issue only)
//   bmem_rdata_i/bmem_rvalid_i : in-order read beats
//
// States
//   LINE_IDLE        | waiting for a request; also the write dfp_resp cycle
//   WAIT             | read command issued, waiting for beat 0
//   SERIALIZE        | driving write beats, cnt = beat on the bus
//   DESERIALIZE      | collecting read beats, cnt = next slot to fill
//   DESERIALIZE_DONE | read dfp_resp cycle, line complete in the buffer
// ---------------------------------------------------------------------------
module param_cacheline_adapter
  import cache_types::*;
#(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [ADDR_WIDTH-1:0]  dfp_addr_i,
  input  logic                   dfp_read_i,
  input  logic                   dfp_write_i,
  input  logic [LINE_WIDTH-1:0]  dfp_wdata_i,
  output logic [LINE_WIDTH-1:0]  dfp_rdata_o,
  output logic                   dfp_resp_o,
  output logic                   crit_valid_o,
  output logic [BURST_WIDTH-1:0] crit_rdata_o,
  output logic [ADDR_WIDTH-1:0]  bmem_addr_o,
  output logic                   bmem_read_o,
  output logic                   bmem_write_o,
  output logic [BURST_WIDTH-1:0] bmem_wdata_o,
  input  logic                   bmem_ready_i,
  input  logic [BURST_WIDTH-1:0] bmem_rdata_i,
  input  logic                   bmem_rvalid_i
);

  localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W  = $clog2(BEATS);
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam int BOFF_W = $clog2(BURST_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  cacheline_state_t       state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   bmem_read_q, bmem_read_d;
  logic                   bmem_write_q, bmem_write_d;
  logic [BURST_WIDTH-1:0] bmem_wdata_q, bmem_wdata_d;
  logic                   dfp_resp_q, dfp_resp_d;

  logic                   buf_load;
  logic                   buf_we;
  logic [BURST_WIDTH-1:0] buf_beat;

  // Offset bits are dropped from the memory address.
  logic unused_addr_lo;
  assign unused_addr_lo = ^dfp_addr_i[OFF_W-1:0];

  assign cnt_inc = cnt_q + 1'b1;

  line_beat_buffer #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH)
  ) u_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (buf_load),
    .load_line_i  (dfp_wdata_i),
    .beat_we_i    (buf_we),
    .beat_widx_i  (cnt_q),
    .beat_wdata_i (bmem_rdata_i),
    .beat_ridx_i  (cnt_inc),
    .beat_rdata_o (buf_beat),
    .line_o       (dfp_rdata_o)
  );

`ifdef CACHELINE_EARLY_RESTART_EN
  logic [CNT_W-1:0]       crit_idx_q, crit_idx_d;
  logic                   crit_valid_q, crit_valid_d;
  logic [BURST_WIDTH-1:0] crit_rdata_q, crit_rdata_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    bmem_read_d  = 1'b0;
    bmem_write_d = 1'b0;
    bmem_wdata_d = '0;
    dfp_resp_d   = 1'b0;
    buf_load     = 1'b0;
    buf_we       = 1'b0;
`ifdef CACHELINE_EARLY_RESTART_EN
    crit_idx_d   = crit_idx_q;
    crit_valid_d = 1'b0;
    crit_rdata_d = crit_rdata_q;
`endif

    unique case (state_q)
      LINE_IDLE: begin
        // dfp_resp_q high means the cache has not yet seen completion and
        // its request line is stale.
        if (!dfp_resp_q && bmem_ready_i) begin
          if (dfp_write_i) begin
            state_d      = SERIALIZE;
            cnt_d        = '0;
            addr_d       = {dfp_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            buf_load     = 1'b1;
            bmem_write_d = 1'b1;
            // Buffer is loaded this edge, so beat 0 comes from the input.
            bmem_wdata_d = dfp_wdata_i[BURST_WIDTH-1:0];
          end else if (dfp_read_i) begin
            state_d     = WAIT;
            cnt_d       = '0;
            addr_d      = {dfp_addr_i[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
            bmem_read_d = 1'b1;
`ifdef CACHELINE_EARLY_RESTART_EN
            crit_idx_d  = dfp_addr_i[OFF_W-1:BOFF_W];
`endif
          end
        end
      end

      SERIALIZE: begin
        if (cnt_q == LAST_BEAT) begin
          state_d    = LINE_IDLE;
          cnt_d      = '0;
          dfp_resp_d = 1'b1;
        end else begin
          cnt_d        = cnt_inc;
          bmem_write_d = 1'b1;
          bmem_wdata_d = buf_beat;
        end
      end

      WAIT, DESERIALIZE: begin
        if (bmem_rvalid_i) begin
          buf_we = 1'b1;
          cnt_d  = cnt_inc;
          if (state_q == WAIT) begin
            state_d = DESERIALIZE;
          end else if (cnt_q == LAST_BEAT) begin
            state_d    = DESERIALIZE_DONE;
            dfp_resp_d = 1'b1;
          end
`ifdef CACHELINE_EARLY_RESTART_EN
          if (cnt_q == crit_idx_q) begin
            crit_valid_d = 1'b1;
            crit_rdata_d = bmem_rdata_i;
          end
`endif
        end
      end

      DESERIALIZE_DONE: begin
        state_d = LINE_IDLE;
      end

      default: begin
        state_d = LINE_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= LINE_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_wdata_q <= '0;
      dfp_resp_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_wdata_q <= bmem_wdata_d;
      dfp_resp_q   <= dfp_resp_d;
    end
  end

`ifdef CACHELINE_EARLY_RESTART_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      crit_idx_q   <= '0;
      crit_valid_q <= 1'b0;
      crit_rdata_q <= '0;
    end else begin
      crit_idx_q   <= crit_idx_d;
      crit_valid_q <= crit_valid_d;
      crit_rdata_q <= crit_rdata_d;
    end
  end

  assign crit_valid_o = crit_valid_q;
  assign crit_rdata_o = crit_rdata_q;
`else
  assign crit_valid_o = 1'b0;
  assign crit_rdata_o = '0;
`endif

  assign bmem_addr_o  = addr_q;
  assign bmem_read_o  = bmem_read_q;
  assign bmem_write_o = bmem_write_q;
  assign bmem_wdata_o = bmem_wdata_q;
  assign dfp_resp_o   = dfp_resp_q;

endmodule : param_cacheline_adapter

// File: tb/tb_param_cacheline_adapter.sv
module tb_param_cacheline_adapter;
  import cache_types::*;

`ifdef CACHELINE_EARLY_RESTART_EN
  localparam bit ER = 1'b1;
`else
  localparam bit ER = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default 256/64 instance
  logic [31:0]  dfp_addr;
  logic         dfp_read, dfp_write;
  logic [255:0] dfp_wdata, dfp_rdata;
  logic         dfp_resp, crit_valid;
  logic [63:0]  crit_rdata;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write, bmem_ready, bmem_rvalid;
  logic [63:0]  bmem_wdata, bmem_rdata;

  // 512/64 instance
  logic [31:0]  w_dfp_addr;
  logic         w_dfp_read, w_dfp_write;
  logic [511:0] w_dfp_wdata, w_dfp_rdata;
  logic         w_dfp_resp, w_crit_valid;
  logic [63:0]  w_crit_rdata;
  logic [31:0]  w_bmem_addr;
  logic         w_bmem_read, w_bmem_write, w_bmem_rvalid;
  logic [63:0]  w_bmem_wdata, w_bmem_rdata;

  param_cacheline_adapter u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .dfp_addr_i(dfp_addr), .dfp_read_i(dfp_read), .dfp_write_i(dfp_write),
    .dfp_wdata_i(dfp_wdata), .dfp_rdata_o(dfp_rdata), .dfp_resp_o(dfp_resp),
    .crit_valid_o(crit_valid), .crit_rdata_o(crit_rdata),
    .bmem_addr_o(bmem_addr), .bmem_read_o(bmem_read), .bmem_write_o(bmem_write),
    .bmem_wdata_o(bmem_wdata), .bmem_ready_i(bmem_ready),
    .bmem_rdata_i(bmem_rdata), .bmem_rvalid_i(bmem_rvalid)
  );

  param_cacheline_adapter #(.LINE_WIDTH(512), .BURST_WIDTH(64), .ADDR_WIDTH(32)) u_dut_w (
    .clk_i(clk), .rst_ni(rst_n),
    .dfp_addr_i(w_dfp_addr), .dfp_read_i(w_dfp_read), .dfp_write_i(w_dfp_write),
    .dfp_wdata_i(w_dfp_wdata), .dfp_rdata_o(w_dfp_rdata), .dfp_resp_o(w_dfp_resp),
    .crit_valid_o(w_crit_valid), .crit_rdata_o(w_crit_rdata),
    .bmem_addr_o(w_bmem_addr), .bmem_read_o(w_bmem_read), .bmem_write_o(w_bmem_write),
    .bmem_wdata_o(w_bmem_wdata), .bmem_ready_i(bmem_ready),
    .bmem_rdata_i(w_bmem_rdata), .bmem_rvalid_i(w_bmem_rvalid)
  );

  logic [63:0] crit_exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Line read on the default instance; gap inserts one idle cycle between beats.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [255:0] line, input bit gap);
    int c;
    logic [63:0] beat;
    c = int'(addr[4:3]);
    dfp_addr = addr;
    dfp_read = 1'b1;
    tick();
    chk({tag, "_cmd"}, bmem_read, 1'b1);
    chk({tag, "_addr"}, bmem_addr, {addr[31:5], 5'b0});
    for (int b = 0; b < 4; b++) begin
      beat        = line[b*64 +: 64];
      bmem_rvalid = 1'b1;
      bmem_rdata  = beat;
      tick();
      if (ER && b == c) crit_exp = beat;
      chk({tag, "_resp"}, dfp_resp, (b == 3));
      chk({tag, "_critv"}, crit_valid, (ER && b == c));
      chk({tag, "_critd"}, crit_rdata, crit_exp);
      chk({tag, "_rd1"}, bmem_read, 1'b0);
      if (gap && b < 3) begin
        bmem_rvalid = 1'b0;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        chk({tag, "_gapresp"}, dfp_resp, 1'b0);
        chk({tag, "_gapcritv"}, crit_valid, 1'b0);
      end
    end
    chk({tag, "_rdata"}, dfp_rdata, line);
    bmem_rvalid = 1'b0;
    dfp_read    = 1'b0;
    tick();
    chk({tag, "_resp_end"}, dfp_resp, 1'b0);
    chk({tag, "_critv_end"}, crit_valid, 1'b0);
    chk({tag, "_state_end"}, u_dut.state_q, LINE_IDLE);
  endtask

  logic [255:0] rline, gline, wline;
  logic [511:0] wl512, rl512;

  initial begin
    rst_n = 1'b0;
    dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b1; bmem_rdata = '0; bmem_rvalid = 1'b0;
    w_dfp_addr = '0; w_dfp_read = 1'b0; w_dfp_write = 1'b0; w_dfp_wdata = '0;
    w_bmem_rdata = '0; w_bmem_rvalid = 1'b0;
    crit_exp = '0;
    tick();
    tick();

    // Reset values
    chk("rst_resp", dfp_resp, 1'b0);
    chk("rst_rdata", dfp_rdata, '0);
    chk("rst_bread", bmem_read, 1'b0);
    chk("rst_bwrite", bmem_write, 1'b0);
    chk("rst_bwdata", bmem_wdata, '0);
    chk("rst_baddr", bmem_addr, '0);
    chk("rst_critv", crit_valid, 1'b0);
    chk("rst_critd", crit_rdata, '0);
    chk("rst_state", u_dut.state_q, LINE_IDLE);
    chk("rst_w_rdata", w_dfp_rdata, '0);
    rst_n = 1'b1;
    tick();

    // bmem_ready low holds the request off
    bmem_ready = 1'b0;
    dfp_read   = 1'b1;
    dfp_addr   = 32'h0000_1234;
    tick();
    chk("notready_read", bmem_read, 1'b0);
    chk("notready_state", u_dut.state_q, LINE_IDLE);
    bmem_ready = 1'b1;
    dfp_read   = 1'b0;

    // Back-to-back read, addr 0x1234 -> 0x1220 (critical beat 2)
    rline = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    do_read("rd", 32'h0000_1234, rline, 1'b0);

    // Write: D0..D3 on consecutive cycles, then dfp_resp
    wline = {64'hD3D3_0000_0000_0003, 64'hD2D2_0000_0000_0002,
             64'hD1D1_0000_0000_0001, 64'hD0D0_0000_0000_0000};
    dfp_addr  = 32'h0000_5678;
    dfp_wdata = wline;
    dfp_write = 1'b1;
    tick();
    chk("wr_addr", bmem_addr, 32'h0000_5660);
    chk("wr_bw0", bmem_write, 1'b1);
    chk("wr_d0", bmem_wdata, 64'hD0D0_0000_0000_0000);
    chk("wr_resp0", dfp_resp, 1'b0);
    tick();
    chk("wr_bw1", bmem_write, 1'b1);
    chk("wr_d1", bmem_wdata, 64'hD1D1_0000_0000_0001);
    tick();
    chk("wr_bw2", bmem_write, 1'b1);
    chk("wr_d2", bmem_wdata, 64'hD2D2_0000_0000_0002);
    tick();
    chk("wr_bw3", bmem_write, 1'b1);
    chk("wr_d3", bmem_wdata, 64'hD3D3_0000_0000_0003);
    chk("wr_resp3", dfp_resp, 1'b0);
    tick();
    chk("wr_resp", dfp_resp, 1'b1);
    chk("wr_bw_end", bmem_write, 1'b0);
    chk("wr_critv", crit_valid, 1'b0);
    // dfp_write still high during the resp cycle: must not restart
    tick();
    chk("wr_ignore_bw", bmem_write, 1'b0);
    chk("wr_ignore_resp", dfp_resp, 1'b0);
    chk("wr_ignore_state", u_dut.state_q, LINE_IDLE);
    dfp_write = 1'b0;

    // Gapped read, addr offset 0 (critical beat 0)
    gline = {64'hA4A4_A4A4_0000_0004, 64'hA3A3_A3A3_0000_0003,
             64'hA2A2_A2A2_0000_0002, 64'hA1A1_A1A1_0000_0001};
    do_read("gap", 32'h0000_2000, gline, 1'b1);

    // Early-restart offset 0x10 on a fresh line (critical beat 2)
    do_read("crit2", 32'h0000_4010, gline, 1'b0);

    // Reset mid-DESERIALIZE, then stray beats
    dfp_addr = 32'h0000_3018;
    dfp_read = 1'b1;
    tick();
    chk("mid_cmd", bmem_read, 1'b1);
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hEEEE_0000_0000_0000;
    tick();
    bmem_rdata  = 64'hEEEE_0000_0000_0001;
    tick();
    chk("mid_state", u_dut.state_q, DESERIALIZE);
    rst_n       = 1'b0;
    dfp_read    = 1'b0;
    bmem_rvalid = 1'b0;
    tick();
    tick();
    crit_exp = '0;
    chk("mid_rst_state", u_dut.state_q, LINE_IDLE);
    chk("mid_rst_resp", dfp_resp, 1'b0);
    chk("mid_rst_rdata", dfp_rdata, '0);
    chk("mid_rst_baddr", bmem_addr, '0);
    chk("mid_rst_bread", bmem_read, 1'b0);
    chk("mid_rst_critd", crit_rdata, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = 64'h5555_0000_0000_0000 | 64'(i);
      tick();
      chk("stray_resp", dfp_resp, 1'b0);
      chk("stray_critv", crit_valid, 1'b0);
      chk("stray_state", u_dut.state_q, LINE_IDLE);
    end
    bmem_rvalid = 1'b0;
    tick();
    chk("stray_resp_end", dfp_resp, 1'b0);

    // 512/64: simultaneous read+write -> write first, then 8-beat read
    for (int i = 0; i < 8; i++) begin
      wl512[i*64 +: 64] = 64'hC0DE_0000_0000_0000 | 64'(i);
      rl512[i*64 +: 64] = {8{8'(8'h10 + i)}};
    end
    w_dfp_addr  = 32'h0000_1234;
    w_dfp_wdata = wl512;
    w_dfp_read  = 1'b1;
    w_dfp_write = 1'b1;
    tick();
    chk("w_pri_write", w_bmem_write, 1'b1);
    chk("w_pri_noread", w_bmem_read, 1'b0);
    chk("w_addr", w_bmem_addr, 32'h0000_1200);
    chk("w_d0", w_bmem_wdata, 64'hC0DE_0000_0000_0000);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("w_bw", w_bmem_write, 1'b1);
      chk("w_d", w_bmem_wdata, 64'hC0DE_0000_0000_0000 | 64'(i));
      chk("w_noresp", w_dfp_resp, 1'b0);
    end
    tick();
    chk("w_wr_resp", w_dfp_resp, 1'b1);
    chk("w_bw_end", w_bmem_write, 1'b0);
    w_dfp_write = 1'b0;
    tick();
    chk("w_resp_ignore", w_bmem_read, 1'b0);
    chk("w_resp_clear", w_dfp_resp, 1'b0);
    tick();
    chk("w_rd_cmd", w_bmem_read, 1'b1);
    for (int i = 0; i < 8; i++) begin
      w_bmem_rvalid = 1'b1;
      w_bmem_rdata  = rl512[i*64 +: 64];
      tick();
      chk("w_rd_resp", w_dfp_resp, (i == 7));
    end
    chk("w_rdata", w_dfp_rdata, rl512);
    chk("w_cnt_wrap", u_dut_w.cnt_q, '0);
    chk("w_critv", w_crit_valid, 1'b0);
    w_bmem_rvalid = 1'b0;
    w_dfp_read    = 1'b0;
    tick();
    chk("w_resp_end", w_dfp_resp, 1'b0);
    chk("w_state_end", u_dut_w.state_q, LINE_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_param_cacheline_adapter

// File: doc/param_cacheline_adapter.md
# param_cacheline_adapter

Parametrised cacheline adapter between the cache controller's line-wide memory port and the burst-oriented memory model. It serializes a dirty line into BEATS consecutive write bursts and deserializes BEATS read bursts into one line, with LINE_WIDTH and BURST_WIDTH both configurable. It replaces the fixed 256/64 adapter. Optionally, it forwards the critical beat to the cache as soon as that beat arrives (early restart).

## Interface
- LINE_WIDTH, 256: cacheline width in bits.
- BURST_WIDTH, 64: memory burst width in bits. BEATS = LINE_WIDTH/BURST_WIDTH must be a power of two and ≥2.
- ADDR_WIDTH, 32: byte address width.
- clk  in  1  single clock.
- rst_n  in  1  reset; synchronous and active-low.
- dfp_addr  in  ADDR_WIDTH  cache request byte address.
- dfp_read  in  1  line read request; held until dfp_resp.
- dfp_write  in  1  line write request; held until dfp_resp.
- dfp_wdata  in  LINE_WIDTH  line to write.
- dfp_rdata  out  LINE_WIDTH  assembled line; valid while dfp_resp.
- dfp_resp  out  1  one-cycle completion pulse.
- crit_valid  out  1  one-cycle pulse: critical beat available.
- crit_rdata  out  BURST_WIDTH  critical beat data.
- bmem_addr  out  ADDR_WIDTH  line-aligned address.
- bmem_read  out  1  one-cycle read command.
- bmem_write  out  1  write beat strobe.
- bmem_wdata  out  BURST_WIDTH  write beat.
- bmem_ready  in  1  memory accepts a new command.
- bmem_rdata  in  BURST_WIDTH  read beat.
- bmem_rvalid  in  1  read beat valid; beats always return in order 0..BEATS-1.

## Operation
- States: LINE_IDLE, WAIT, SERIALIZE, DESERIALIZE, DESERIALIZE_DONE.
- LINE_IDLE:
  - dfp_write & bmem_ready → SERIALIZE. Latch dfp_wdata and set beat counter = 0.
  - else dfp_read & bmem_ready → WAIT. Assert bmem_read for exactly one cycle.
  - Write has priority if both requests are high.
  - bmem_ready low → stay in LINE_IDLE.
- SERIALIZE:
  - bmem_write = 1 and bmem_wdata = beat[cnt] each cycle; cnt increments.
  - After beat BEATS-1 → LINE_IDLE, with dfp_resp = 1 for that next cycle.
- WAIT: first bmem_rvalid stores beat 0 and sets cnt = 1 → DESERIALIZE.
- DESERIALIZE:
  - Each bmem_rvalid stores beat[cnt] and increments cnt.
  - Gaps with rvalid low hold state.
  - Storing beat BEATS-1 → DESERIALIZE_DONE.
- DESERIALIZE_DONE: dfp_resp = 1 and dfp_rdata = assembled line for one cycle → LINE_IDLE.
- bmem_addr = dfp_addr with the low $clog2(LINE_WIDTH/8) bits zeroed, held from the command cycle through the last beat.
- Beat counter is $clog2(BEATS) bits and wraps to 0 after BEATS-1.
- bmem_rvalid in LINE_IDLE or SERIALIZE is ignored.
- Requests seen in the dfp_resp cycle are ignored; LINE_IDLE samples again on the following cycle.

## Timing
- Reset values: every output 0, state LINE_IDLE, counter 0, line buffer 0.
- Reset mid-operation aborts the transfer. Beats arriving after reset are ignored.
- Outputs are registered.
- Read:
  - Request sampled at cycle T → bmem_read at T+1.
  - Last rvalid at cycle L → dfp_resp at L+1. Adapter accepts a new request at L+2.
  - Minimum total latency: T+1+BEATS+1.
- Write:
  - Request sampled at cycle T → bmem_write at T+1..T+BEATS.
  - dfp_resp at T+BEATS+1.
- bmem_ready is checked only at command issue, not per beat.

## Configuration
- Macro: CACHELINE_EARLY_RESTART_EN.
- With the macro defined:
  - Critical index c = dfp_addr[$clog2(LINE_WIDTH/8)-1 : $clog2(BURST_WIDTH/8)].
  - The cycle after beat c arrives, crit_valid = 1 for one cycle and crit_rdata = that beat.
  - dfp_resp timing is unchanged.
  - crit_valid pulses exactly once per read and never on writes.
- Without the macro: crit_valid and crit_rdata are tied to 0. The ports remain present.

## Structure
- cache_types package holds cacheline_state_t (LINE_IDLE, WAIT, SERIALIZE, DESERIALIZE, DESERIALIZE_DONE).
- BEATS and counter-width localparams are derived inside the module from the parameters.
- One sub-module, line_beat_buffer:
  - Stores LINE_WIDTH bits.
  - Supports indexed beat write (read path) and indexed beat read (write path).

## Test plan
- Reset: rst_n low for 2 cycles mid-DESERIALIZE → all outputs 0 and state LINE_IDLE. Stray rvalid beats are then ignored with no dfp_resp.
- Read, defaults, addr 0x0000_1234:
  - bmem_addr = 0x0000_1220; beats 0x11..,0x22..,0x33..,0x44.. arrive back-to-back.
  - dfp_rdata = {beat3,beat2,beat1,beat0}; dfp_resp exactly 1 cycle after the last beat.
- Write, defaults: dfp_wdata = {D3,D2,D1,D0} → bmem_wdata D0,D1,D2,D3 on 4 consecutive cycles, then dfp_resp for 1 cycle.
- Gapped read with rvalid low between every beat → same dfp_rdata. Cycle count = first beat + 7 + 1.
- LINE_WIDTH=512, BURST_WIDTH=64:
  - Read collects 8 beats and the counter wraps to 0.
  - Simultaneous dfp_read and dfp_write → write is serviced first.
- With CACHELINE_EARLY_RESTART_EN, addr offset 0x10 (c=2) → crit_valid one cycle after beat 2 with crit_rdata = beat 2. With addr offset 0x00, it pulses after beat 0.
